// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [1:0] STARVE_LIMIT = 2'd3;
  localparam int MEM_LAT_DEFAULT = 1;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data-stage requesters
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic [31:0] IRdata,
  output logic        IDone,
  input  logic        DReq,
  input  logic        DWrite,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWdata,
  output logic [31:0] DRdata,
  output logic        DDone,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWdata,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] MemRdata,
  output logic        Stall
);
  state_t      r_state, w_next;
  logic        r_id_d;
  logic        r_write;
  logic [31:0] r_addr, r_wdata, r_irdata, r_drdata;
  logic [1:0]  r_starve;
  logic [2:0]  r_lat;
  logic        w_grant_i, w_grant_d, w_last;
  assign w_grant_i = IReq && (!DReq || r_starve == STARVE_LIMIT);
  assign w_grant_d = DReq && !w_grant_i;
  assign w_last    = r_lat == 3'd0;
  assign IRdata    = r_irdata;
  assign DRdata    = r_drdata;
  assign MemAddr   = r_addr;
  assign MemWdata  = r_wdata;
  assign Stall     = (IReq && !IDone) || (DReq && !DDone);
  // state register
  always_ff @(posedge Clk) begin
    if (Rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state and strobe/pulse decode
  always_comb begin
    w_next   = r_state;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IDone    = 1'b0;
    DDone    = 1'b0;
    unique case (r_state)
      IDLE:  w_next = (IReq || DReq) ? ISSUE : IDLE;
      ISSUE: begin
        MemRead  = !r_write;
        MemWrite = r_write;
        w_next   = r_write ? DONE : WAIT;
      end
      WAIT:  w_next = w_last ? DONE : WAIT;
      DONE:  begin
        IDone  = !r_id_d;
        DDone  = r_id_d;
        w_next = IDLE;
      end
    endcase
  end
  // grant latching, starvation tracking, latency count and read-data capture
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_id_d   <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_irdata <= '0;
      r_drdata <= '0;
      r_starve <= '0;
      r_lat    <= '0;
    end else begin
      if (r_state == IDLE) begin
        if (IReq || DReq) begin
          r_id_d  <= w_grant_d;
          r_addr  <= w_grant_d ? DAddr : IAddr;
          r_write <= w_grant_d && DWrite;
          if (w_grant_d && DWrite) r_wdata <= DWdata;
        end
        r_starve <= (!IReq || w_grant_i) ? 2'd0 : r_starve + 2'd1;
      end
      if (r_state == ISSUE) r_lat <= 3'(MEM_LAT - 1);
      if (r_state == WAIT) begin
        r_lat <= w_last ? 3'd0 : r_lat - 3'd1;
        if (w_last && r_id_d) r_drdata <= MemRdata;
        if (w_last && !r_id_d) r_irdata <= MemRdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a timing model
module tb_mem_port_arbiter;
  logic Clk = 1'b0, Rst = 1'b1;
  logic IReq = 0, DReq = 0, DWrite = 0;
  logic [31:0] IAddr = 0, DAddr = 0, DWdata = 0;
  logic [31:0] i_rd1, d_rd1, m_addr1, m_wd1, m_rdata1;
  logic i_done1, d_done1, m_rd1, m_wr1, stall1;
  logic [31:0] i_rd3, d_rd3, m_addr3, m_wd3, m_rdata3;
  logic i_done3, d_done3, m_rd3, m_wr3, stall3;
  int total = 0, bad = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h40) ? 32'h1234ABCD : {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
  endfunction

  logic rv1 = 1'b0, force1 = 1'b0;
  logic [31:0] ra1 = '0;
  logic [2:0] rv3 = '0;
  logic [31:0] ra3 [3] = '{default: '0};
  always @(posedge Clk) begin
    rv1 <= m_rd1;
    ra1 <= m_addr1;
    rv3 <= {rv3[1:0], m_rd3};
    ra3[2] <= ra3[1];
    ra3[1] <= ra3[0];
    ra3[0] <= m_addr3;
  end
  assign m_rdata1 = force1 ? mem_fn(32'h40) : rv1 ? mem_fn(ra1) : 32'hBAD0BAD0;
  assign m_rdata3 = rv3[2] ? mem_fn(ra3[2]) : 32'hBAD0BAD0;

  mem_port_arbiter #(.MEM_LAT(1)) dut1 (
    .Clk(Clk), .Rst(Rst), .IReq(IReq), .IAddr(IAddr), .IRdata(i_rd1), .IDone(i_done1),
    .DReq(DReq), .DWrite(DWrite), .DAddr(DAddr), .DWdata(DWdata), .DRdata(d_rd1), .DDone(d_done1),
    .MemAddr(m_addr1), .MemWdata(m_wd1), .MemRead(m_rd1), .MemWrite(m_wr1), .MemRdata(m_rdata1),
    .Stall(stall1));
  mem_port_arbiter #(.MEM_LAT(3)) dut3 (
    .Clk(Clk), .Rst(Rst), .IReq(IReq), .IAddr(IAddr), .IRdata(i_rd3), .IDone(i_done3),
    .DReq(DReq), .DWrite(DWrite), .DAddr(DAddr), .DWdata(DWdata), .DRdata(d_rd3), .DDone(d_done3),
    .MemAddr(m_addr3), .MemWdata(m_wd3), .MemRead(m_rd3), .MemWrite(m_wr3), .MemRdata(m_rdata3),
    .Stall(stall3));

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1; IReq = 0; DReq = 0; DWrite = 0; IAddr = 0; DAddr = 0; DWdata = 0; force1 = 0;
    repeat (2) @(negedge Clk);
    Rst = 0;
  endtask

  initial begin
    logic [31:0] exp_seq [8];
    int k;
    int issue_c, done_c, next_free, starve;
    bit busy, cur_d, cur_w, gi, ion, don, dw;
    logic [31:0] cur_a, cur_wd, ia, da, dwd, exp_ir, exp_dr;
    logic ed_i, ed_d;

    // reset state
    repeat (2) @(negedge Clk);
    #1;
    chk("rst_irdata", i_rd1, 0);
    chk("rst_drdata", d_rd1, 0);
    chk("rst_memaddr", m_addr1, 0);
    chk("rst_memwdata", m_wd1, 0);
    chk("rst_strobes", {m_rd1, m_wr1, i_done1, d_done1, stall1}, 0);
    chk("rst3_outs", {i_rd3, d_rd3, m_addr3, m_wd3} == 0, 1);
    chk("rst3_strobes", {m_rd3, m_wr3, i_done3, d_done3, stall3}, 0);
    Rst = 0;

    // lone read, MEM_LAT=1
    do_reset();
    @(negedge Clk); IReq = 1; IAddr = 32'h40; #1;
    chk("rd_t0_stall", stall1, 1); chk("rd_t0_memread", m_rd1, 0);
    @(negedge Clk); #1;
    chk("rd_t1_memread", m_rd1, 1); chk("rd_t1_addr", m_addr1, 32'h40);
    chk("rd_t1_stall", stall1, 1); chk("rd_t1_idone", i_done1, 0);
    @(negedge Clk); #1;
    chk("rd_t2_memread", m_rd1, 0); chk("rd_t2_stall", stall1, 1); chk("rd_t2_idone", i_done1, 0);
    @(negedge Clk); #1;
    chk("rd_t3_idone", i_done1, 1); chk("rd_t3_irdata", i_rd1, 32'h1234ABCD);
    chk("rd_t3_stall", stall1, 0); chk("rd_t3_ddone", d_done1, 0);
    IReq = 0;
    @(negedge Clk); #1;
    chk("rd_t4_idone", i_done1, 0); chk("rd_t4_hold", i_rd1, 32'h1234ABCD); chk("rd_t4_memread", m_rd1, 0);

    // lone store
    do_reset();
    @(negedge Clk); DReq = 1; DWrite = 1; DAddr = 32'h100; DWdata = 32'hDEADBEEF; #1;
    chk("st_t0_strobes", {m_rd1, m_wr1}, 0);
    @(negedge Clk); #1;
    chk("st_t1_strobes", {m_rd1, m_wr1}, 2'b01);
    chk("st_t1_addr", m_addr1, 32'h100); chk("st_t1_wdata", m_wd1, 32'hDEADBEEF);
    @(negedge Clk); #1;
    chk("st_t2_ddone", d_done1, 1); chk("st_t2_strobes", {m_rd1, m_wr1}, 0); chk("st_t2_stall", stall1, 0);
    DReq = 0; DWrite = 0;
    @(negedge Clk); #1;
    chk("st_t3_hold", {m_addr1, m_wd1} == {32'h100, 32'hDEADBEEF}, 1);

    // simultaneous requests held continuously
    exp_seq = '{32'h300, 32'h300, 32'h300, 32'h200, 32'h300, 32'h300, 32'h300, 32'h200};
    do_reset();
    @(negedge Clk); IReq = 1; IAddr = 32'h200; DReq = 1; DWrite = 0; DAddr = 32'h300;
    k = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk); #1;
      if (m_rd1 && k < 8) begin
        chk($sformatf("grant_%0d", k), m_addr1, exp_seq[k]);
        k++;
      end
    end
    chk("grant_count", k, 8);

    // MEM_LAT=3 data read
    do_reset();
    @(negedge Clk); DReq = 1; DWrite = 0; DAddr = 32'h8; #1;
    chk("l3_t0_memread", m_rd3, 0);
    @(negedge Clk); #1;
    chk("l3_t1_memread", m_rd3, 1); chk("l3_t1_addr", m_addr3, 32'h8);
    repeat (2) begin
      @(negedge Clk); #1;
      chk("l3_wait", {m_rd3, d_done3}, 0);
    end
    @(negedge Clk); #1;
    chk("l3_t4_ddone", d_done3, 0); chk("l3_t4_drdata", d_rd3, 0);
    @(negedge Clk); #1;
    chk("l3_t5_ddone", d_done3, 1); chk("l3_t5_drdata", d_rd3, mem_fn(32'h8));
    DReq = 0;

    // reset during WAIT
    do_reset();
    @(negedge Clk); IReq = 1; IAddr = 32'h40;
    @(negedge Clk); #1;
    chk("rw_t1_memread", m_rd1, 1);
    @(negedge Clk); Rst = 1; IReq = 0;
    @(negedge Clk); Rst = 0; force1 = 1; #1;
    chk("rw_t3_idone", i_done1, 0); chk("rw_t3_irdata", i_rd1, 0); chk("rw_t3_memread", m_rd1, 0);
    @(negedge Clk); force1 = 0; #1;
    chk("rw_t4_idone", i_done1, 0); chk("rw_t4_irdata", i_rd1, 0);
    @(negedge Clk); IReq = 1; IAddr = 32'h44;
    @(negedge Clk); #1;
    chk("rw_new_memread", m_rd1, 1); chk("rw_new_addr", m_addr1, 32'h44);
    @(negedge Clk);
    @(negedge Clk); #1;
    chk("rw_new_idone", i_done1, 1); chk("rw_new_irdata", i_rd1, mem_fn(32'h44));
    IReq = 0;

    // randomized traffic against a transaction-timing model, MEM_LAT=1
    do_reset();
    busy = 0; issue_c = -1; done_c = -1; next_free = 0; starve = 0;
    ion = 0; don = 0; dw = 0; ia = 0; da = 0; dwd = 0; exp_ir = 0; exp_dr = 0;
    cur_d = 0; cur_w = 0; cur_a = 0; cur_wd = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge Clk);
      ed_i = busy && c == done_c && !cur_d;
      ed_d = busy && c == done_c && cur_d;
      if (ed_i) begin ion = 0; exp_ir = mem_fn(cur_a); end
      if (ed_d) begin don = 0; if (!cur_w) exp_dr = mem_fn(cur_a); end
      if (!ion && $urandom_range(0, 1) == 1) begin ion = 1; ia = $urandom; end
      if (!don && $urandom_range(0, 2) != 0) begin
        don = 1; dw = 1'($urandom_range(0, 1)); da = $urandom; dwd = $urandom;
      end
      IReq = ion; IAddr = ia; DReq = don; DWrite = dw; DAddr = da; DWdata = dwd;
      #1;
      chk("rnd_idone", i_done1, ed_i);
      chk("rnd_ddone", d_done1, ed_d);
      chk("rnd_memread", m_rd1, busy && c == issue_c && !cur_w);
      chk("rnd_memwrite", m_wr1, busy && c == issue_c && cur_w);
      chk("rnd_irdata", i_rd1, exp_ir);
      chk("rnd_drdata", d_rd1, exp_dr);
      chk("rnd_stall", stall1, (ion && !ed_i) || (don && !ed_d));
      if (busy && c == issue_c) begin
        chk("rnd_memaddr", m_addr1, cur_a);
        if (cur_w) chk("rnd_memwdata", m_wd1, cur_wd);
      end
      if (busy && c == done_c) busy = 0;
      if (!busy && c >= next_free) begin
        if (!ion) starve = 0;
        if (ion || don) begin
          gi = ion && (!don || starve == 3);
          if (gi) starve = 0;
          else if (ion) starve++;
          busy = 1; cur_d = !gi; cur_w = !gi && dw; cur_a = gi ? ia : da; cur_wd = dwd;
          issue_c = c + 1; done_c = c + (cur_w ? 2 : 3); next_free = done_c + 1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The module SHALL have one parameter: MEM_LAT, default 1, meaning cycles from the MemRead strobe to valid MemRdata (legal range 1-4).
REQ-002 The module SHALL have the following ports, one per line:
  Clk  in  1  sole clock, rising edge
  Rst  in  1  synchronous, active-high reset
  IReq  in  1  fetch read request, level, held until IDone
  IAddr  in  32  fetch address, stable while IReq is high
  IRdata  out  32  fetch read data, valid when IDone is high
  IDone  out  1  one-cycle fetch completion pulse
  DReq  in  1  data-stage request, level, held until DDone
  DWrite  in  1  1 = store, 0 = load; stable while DReq is high
  DAddr  in  32  data address
  DWdata  in  32  store data (already byte-masked upstream)
  DRdata  out  32  load data, valid when DDone is high
  DDone  out  1  one-cycle data completion pulse
  MemAddr  out  32  shared single-port memory address
  MemWdata  out  32  shared memory write data
  MemRead  out  1  one-cycle read strobe
  MemWrite  out  1  one-cycle write strobe
  MemRdata  in  32  memory read data, valid MEM_LAT cycles after MemRead
  Stall  out  1  pipeline freeze request
REQ-003 The block SHALL use one clock, Clk; Rst SHALL be synchronous and active-high.

Function
REQ-004 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-005 IDLE SHALL arbitrate on every cycle.
  Winner is chosen only if DReq or IReq is high.
  On a win: latch the winner ID, address, DWrite and DWdata into registers; go to ISSUE.
REQ-006 Priority SHALL be: DReq over IReq, except when starve_cnt = 3 and IReq is high, in which case IReq wins.
REQ-007 starve_cnt (2-bit) SHALL increment on each D grant made while IReq is high, and clear on an I grant or on any IDLE cycle with IReq low.
REQ-008 ISSUE SHALL last exactly one cycle.
  MemAddr = latched address.
  Read: MemRead = 1, then go to WAIT.
  Write: MemWrite = 1, MemWdata = latched DWdata, then go to DONE.
REQ-009 WAIT SHALL last exactly MEM_LAT cycles (down-counter). On the last WAIT cycle, MemRdata SHALL be captured into IRdata or DRdata per the winner ID; then go to DONE.
REQ-010 DONE SHALL last one cycle.
  Pulse IDone or DDone for the winner.
  Return to IDLE; no arbitration occurs in DONE.
REQ-011 Latency, request seen in IDLE at cycle t:
  Read Done at t + 2 + MEM_LAT.
  Write Done at t + 2.
REQ-012 MemRead and MemWrite SHALL never both be high. Neither SHALL be high outside ISSUE.
REQ-013 A requester still high in the DONE cycle SHALL be treated as a new request in the next IDLE cycle (back-to-back throughput = one access per 3 + MEM_LAT cycles for reads).
REQ-014 A request dropped mid-access (protocol violation) SHALL NOT abort the access: the access completes and Done still pulses.
REQ-015 IRdata and DRdata SHALL hold their last captured value until the next capture for that requester.
REQ-016 Stall SHALL be combinational: (IReq & ~IDone) | (DReq & ~DDone).
REQ-017 MemAddr and MemWdata SHALL hold their last latched values outside ISSUE.

Reset
REQ-018 When Rst is high at a clock edge, the block SHALL:
  Enter IDLE.
  Clear starve_cnt and the latency counter.
  Drive IRdata = DRdata = MemAddr = MemWdata = 0 and IDone = DDone = MemRead = MemWrite = 0.
REQ-019 Reset mid-access SHALL discard the in-flight access with no Done pulse. MemRdata arriving afterwards SHALL be ignored.

Structure
REQ-020 Package mem_arb_pkg SHALL hold the state enum, STARVE_LIMIT = 3, and the MEM_LAT default.
REQ-021 No sub-module SHALL be used. The FSM, latency counter and starvation counter are internal to mem_port_arbiter.

Verification
REQ-022 The bench SHALL cover these directed scenarios, with MEM_LAT = 1 unless noted:
  Lone read: IReq at t0, IAddr = 0x40, memory returns 0x1234ABCD -> MemRead at t1 only; IDone and IRdata = 0x1234ABCD at t3; Stall high t0 to t2, low at t3.
  Lone store: DReq = DWrite = 1, DAddr = 0x100, DWdata = 0xDEADBEEF -> MemWrite at t1 with those values; DDone at t2; MemRead never high.
  Simultaneous requests: DReq and IReq held continuously -> grant order D, D, D, I, D, D, D, I; IDone interval never exceeds 4 D accesses.
  MEM_LAT = 3 read: DAddr = 0x8 -> MemRead at t1; capture at t4; DDone at t5.
  Reset in WAIT: Rst at t2 of a read -> state IDLE; no IDone; IRdata = 0; late MemRdata ignored; a new IReq afterwards completes normally.
